// File: rtl/piso_sreg.sv
// Parallel-in serial-out shift register with valid/ready load side.
// Words stream back-to-back when a new one is offered on the last bit.
module piso_sreg #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pinp,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LASTC = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shl;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             accept;

    assign last   = (cnt == LASTC);
    assign accept = load_valid & load_ready;

    // One-position shift toward the output end, zero filled
    always_comb begin
        sreg_shl = '0;
        if (MSB_FIRST) begin
            sreg_shl = {sreg[WIDTH-2:0], 1'b0};
        end else begin
            sreg_shl = {1'b0, sreg[WIDTH-1:1]};
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: load starts a word, last consumed bit ends it
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (done && !accept) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; sreg is zero whenever idle, so sout is 0 then
    always_comb begin
        busy       = (state == SHIFT);
        sout_valid = busy;
        done       = sout_valid & last & shift_en;
        load_ready = ~busy | (last & shift_en);
        sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    end

    // Shift register and bit counter; hold while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= pinp;
            cnt  <= '0;
        end else if (busy && shift_en) begin
            if (last) begin
                sreg <= '0;
                cnt  <= '0;
            end else begin
                sreg <= sreg_shl;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_sreg.sv
// Directed bench for piso_sreg, WIDTH=4.
// Both bit orders share stimulus; LSB order checked on the first word.
module tb_piso_sreg;

    logic       clk;
    logic       reset;
    logic [3:0] pinp;
    logic       load_valid;
    logic       shift_en;

    logic m_ready, m_sout, m_sv, m_busy, m_done;
    logic l_ready, l_sout, l_sv, l_busy, l_done;

    int checks;
    int errors;

    piso_sreg #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clk        (clk),
        .reset      (reset),
        .pinp       (pinp),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .shift_en   (shift_en),
        .sout       (m_sout),
        .sout_valid (m_sv),
        .busy       (m_busy),
        .done       (m_done)
    );

    piso_sreg #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clk        (clk),
        .reset      (reset),
        .pinp       (pinp),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .shift_en   (shift_en),
        .sout       (l_sout),
        .sout_valid (l_sv),
        .busy       (l_busy),
        .done       (l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then check this cycle's outputs
    task automatic cyc(input string tag, input logic lv,
                       input logic [3:0] p, input logic se,
                       input logic esv, input logic eso,
                       input logic edn, input logic elr);
        @(negedge clk);
        load_valid = lv;
        pinp       = p;
        shift_en   = se;
        #1;
        check({tag, ".sv"},    m_sv,    esv);
        check({tag, ".sout"},  m_sout,  eso);
        check({tag, ".busy"},  m_busy,  esv);
        check({tag, ".done"},  m_done,  edn);
        check({tag, ".ready"}, m_ready, elr);
        check({tag, ".l_sv"},    l_sv,    esv);
        check({tag, ".l_busy"},  l_busy,  esv);
        check({tag, ".l_done"},  l_done,  edn);
        check({tag, ".l_ready"}, l_ready, elr);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        load_valid = 1'b0;
        pinp       = 4'b0000;
        shift_en   = 1'b0;

        // Reset state, with a word already offered
        @(negedge clk);
        load_valid = 1'b1;
        pinp       = 4'b0011;
        shift_en   = 1'b1;
        #1;
        check("rst.sout",  m_sout,  1'b0);
        check("rst.sv",    m_sv,    1'b0);
        check("rst.busy",  m_busy,  1'b0);
        check("rst.done",  m_done,  1'b0);
        check("rst.ready", m_ready, 1'b1);
        check("rst.l_sout", l_sout, 1'b0);
        reset = 1'b0;

        // MSB first 0011 -> 0,0,1,1; LSB first -> 1,1,0,0
        cyc("t1b1", 0, 4'b0000, 1, 1, 0, 0, 0);
        check("t1b1.l_sout", l_sout, 1'b1);
        cyc("t1b2", 0, 4'b0000, 1, 1, 0, 0, 0);
        check("t1b2.l_sout", l_sout, 1'b1);
        cyc("t1b3", 0, 4'b0000, 1, 1, 1, 0, 0);
        check("t1b3.l_sout", l_sout, 1'b0);
        cyc("t1b4", 0, 4'b0000, 1, 1, 1, 1, 1);
        check("t1b4.l_sout", l_sout, 1'b0);
        cyc("t1idle", 0, 4'b0000, 1, 0, 0, 0, 1);
        check("t1idle.l_sout", l_sout, 1'b0);

        // Back-to-back 0011 then 1100
        cyc("t2ld", 1, 4'b0011, 1, 0, 0, 0, 1);
        cyc("t2b1", 1, 4'b1100, 1, 1, 0, 0, 0);
        cyc("t2b2", 1, 4'b1100, 1, 1, 0, 0, 0);
        cyc("t2b3", 1, 4'b1100, 1, 1, 1, 0, 0);
        cyc("t2b4", 1, 4'b1100, 1, 1, 1, 1, 1);
        cyc("t2b5", 0, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t2b6", 0, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t2b7", 0, 4'b0000, 1, 1, 0, 0, 0);
        cyc("t2b8", 0, 4'b0000, 1, 1, 0, 1, 1);

        // Stall: 1010 with two stalled cycles on the second bit
        cyc("t3ld", 1, 4'b1010, 1, 0, 0, 0, 1);
        cyc("t3c1", 0, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t3c2", 0, 4'b0000, 0, 1, 0, 0, 0);
        cyc("t3c3", 0, 4'b0000, 0, 1, 0, 0, 0);
        cyc("t3c4", 0, 4'b0000, 1, 1, 0, 0, 0);
        cyc("t3c5", 0, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t3c6", 0, 4'b0000, 1, 1, 0, 1, 1);

        // Busy reject: 0000 offered mid-word, taken on the last bit
        cyc("t4ld", 1, 4'b1111, 1, 0, 0, 0, 1);
        cyc("t4b1", 0, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t4b2", 1, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t4b3", 1, 4'b0000, 1, 1, 1, 0, 0);
        cyc("t4b4", 1, 4'b0000, 1, 1, 1, 1, 1);
        cyc("t4z1", 0, 4'b0000, 1, 1, 0, 0, 0);
        cyc("t4z2", 0, 4'b0000, 1, 1, 0, 0, 0);
        cyc("t4z3", 0, 4'b0000, 1, 1, 0, 0, 0);
        cyc("t4z4", 0, 4'b0000, 1, 1, 0, 1, 1);

        // Reset during bit 2 of 1001
        cyc("t5ld", 1, 4'b1001, 1, 0, 0, 0, 1);
        cyc("t5b1", 0, 4'b0000, 1, 1, 1, 0, 0);
        @(negedge clk);
        reset      = 1'b1;
        load_valid = 1'b0;
        shift_en   = 1'b1;
        #1;
        check("t5rst.sout",  m_sout,  1'b0);
        check("t5rst.sv",    m_sv,    1'b0);
        check("t5rst.busy",  m_busy,  1'b0);
        check("t5rst.done",  m_done,  1'b0);
        check("t5rst.ready", m_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        cyc("t5post", 0, 4'b0000, 1, 0, 0, 0, 1);
        cyc("t5post2", 0, 4'b0000, 1, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_sreg.md
PISO_SREG -- requirements
Module: piso_sreg

Interface
REQ-001 SHALL have parameter WIDTH, default 4: word width in bits, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 transmitted first, 0 = bit 0 first.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pinp  input  WIDTH  parallel word to be serialised.
REQ-006 SHALL have port load_valid  input  1  pinp holds a word offered for loading.
REQ-007 SHALL have port load_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port shift_en  input  1  consumer takes the current serial bit this cycle; 0 = stall.
REQ-009 SHALL have port sout  output  1  serial data bit.
REQ-010 SHALL have port sout_valid  output  1  sout carries a valid data bit.
REQ-011 SHALL have port busy  output  1  a word is in flight (state SHIFT).
REQ-012 SHALL have port done  output  1  last bit of the word is consumed this cycle.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-014 SHALL define accept as load_valid & load_ready, sampled at a rising clk edge.
REQ-015 SHALL, on accept, capture pinp into a WIDTH-bit shift register, clear the bit counter to 0, and enter SHIFT.
REQ-016 SHALL assert sout_valid and busy from the cycle after accept until the last bit is consumed; latency from accept edge to first valid bit = 1 cycle.
REQ-017 SHALL drive sout from a register: MSB of the shift register when MSB_FIRST=1, LSB when MSB_FIRST=0.
REQ-018 SHALL, at each edge in SHIFT with shift_en=1, shift the register by one position (zero fill) and increment the counter (width clog2(WIDTH)).
REQ-019 SHALL, at an edge with shift_en=0, hold the shift register, counter, sout and sout_valid unchanged.
REQ-020 SHALL treat the bit as last when counter == WIDTH-1; the counter never exceeds WIDTH-1.
REQ-021 SHALL drive done combinationally = sout_valid & last & shift_en; done is high for exactly one consumed bit per word.
REQ-022 SHALL drive load_ready combinationally = ~busy | (last & shift_en), allowing back-to-back words with no gap bit.
REQ-023 SHALL, on accept coinciding with done, load the new word, clear the counter and remain in SHIFT, so sout_valid stays high continuously.
REQ-024 SHALL, on done without accept, return to IDLE; sout_valid and busy drop and sout returns to 0 the following cycle.
REQ-025 SHALL ignore load_valid and pinp while load_ready=0; the in-flight word is never corrupted.
REQ-026 SHALL keep sout = 0 whenever sout_valid = 0.

Reset
REQ-027 SHALL, while reset=1, force state IDLE, shift register 0, counter 0, sout 0, sout_valid 0, busy 0; done 0 and load_ready 1 follow combinationally.
REQ-028 SHALL, on reset asserted mid-word, abort immediately without completing the word and without a done pulse.
REQ-029 SHALL accept a word at the first rising edge after reset deasserts if load_valid=1.

Verification (WIDTH=4)
REQ-030 SHALL verify MSB_FIRST=1: load 4'b0011, shift_en=1 -> sout 0,0,1,1 on cycles 1..4 after accept, sout_valid high exactly 4 cycles, done only in cycle 4.
REQ-031 SHALL verify back-to-back: 4'b0011 then 4'b1100 offered while load_valid stays high -> 8 contiguous valid bits 0,0,1,1,1,1,0,0, two done pulses, no gap.
REQ-032 SHALL verify stall: load 4'b1010, shift_en=0 for 2 cycles after the second bit -> sout holds 0 for 3 cycles, total 6 valid cycles, sequence 1,0,1,0 preserved.
REQ-033 SHALL verify busy reject: load 4'b1111, then offer 4'b0000 during bit 2 -> load_ready=0, output remains 1,1,1,1, then 4'b0000 accepted with done.
REQ-034 SHALL verify reset mid-word: load 4'b1001, assert reset during bit 2 -> sout=0, sout_valid=0, busy=0 immediately, no done, load_ready=1.
REQ-035 SHALL verify MSB_FIRST=0: load 4'b0011 -> sout 1,1,0,0.
